// File: rtl/skewed_feeder_if.sv
// Load handshake and skewed stream bundle between the
// array controller and the operand feeder.
interface skewed_feeder_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int LANES  = 4
);
    logic                            load_valid;
    logic                            load_ready;
    logic [LANES*DEPTH*DATA_W-1:0]   load_data;
    logic                            enable;
    logic                            abort;
    logic [LANES*DATA_W-1:0]         data_out;
    logic                            out_valid;
    logic                            done;

    modport master (
        output load_valid, load_data, enable, abort,
        input  load_ready, data_out, out_valid, done
    );

    modport slave (
        input  load_valid, load_data, enable, abort,
        output load_ready, data_out, out_valid, done
    );
endinterface

// File: rtl/skewed_feeder.sv
// Operand feeder: buffers one block and streams it as a
// diagonal wavefront, lane i lagging lane 0 by i steps.
module skewed_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int LANES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    skewed_feeder_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + LANES);
    localparam logic [CW-1:0] LAST = CW'(DEPTH + LANES - 2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [DATA_W-1:0]        mem [LANES][DEPTH];
    logic [LANES*DATA_W-1:0]  data_mux;
    logic                     last_step;

    assign last_step = (state == STREAM) && bus.enable && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            mem   <= '{default: '0};
        end else if (bus.abort) begin
            state <= IDLE;
            cnt   <= '0;
            mem   <= '{default: '0};
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        for (int i = 0; i < LANES; i++)
                            for (int k = 0; k < DEPTH; k++)
                                mem[i][k] <= bus.load_data[(i*DEPTH+DEPTH-1-k)*DATA_W +: DATA_W];
                        cnt   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.enable) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane i shows element k exactly when cnt == i+k; all else pads zero.
    always_comb begin
        data_mux = '0;
        if (state == STREAM)
            for (int i = 0; i < LANES; i++)
                for (int k = 0; k < DEPTH; k++)
                    if (cnt == CW'(i + k))
                        data_mux[i*DATA_W +: DATA_W] = mem[i][k];
    end

    assign bus.load_ready = (state == IDLE) && !bus.abort;
    assign bus.out_valid  = (state == STREAM);
    assign bus.done       = last_step && !bus.abort;
    assign bus.data_out   = data_mux;
endmodule

// File: tb/tb_skewed_feeder.sv
// Directed and scoreboard checks of the skewed feeder over
// the default shape and three parameter corners.
`define RUN_BLOCKS(IF, DW, DP, LN, NB, RND, NM) \
    begin \
        rs = 0; rb = 0; cyc = 0; st = 0; \
        nhs = 0; ndn = 0; nvl = 0; hsa = -1; hsb = -1; \
        while (cyc < 600 && !(nhs == NB && !st)) begin \
            @(posedge clk); #1; \
            IF.load_valid = (nhs < NB); \
            for (int i = 0; i < LN; i++) \
                for (int k = 0; k < DP; k++) \
                    IF.load_data[(i*DP+DP-1-k)*DW +: DW] = elem[(nhs < NB) ? nhs : 0][i][k][DW-1:0]; \
            IF.enable = RND ? 1'($urandom_range(0, 1)) : 1'b1; \
            @(negedge clk); \
            if (st) begin \
                chk({NM, ".ov"}, longint'(IF.out_valid), 1); \
                chk({NM, ".dat"}, longint'(IF.data_out), exp_word(rb, rs, DW, DP, LN)); \
                chk({NM, ".done"}, longint'(IF.done), longint'(IF.enable && rs == DP+LN-2)); \
                if (IF.done) ndn++; \
                if (IF.enable) begin \
                    nvl++; \
                    if (rs == DP+LN-2) st = 0; \
                    else rs++; \
                end \
            end else begin \
                chk({NM, ".idle"}, longint'(IF.out_valid), 0); \
                chk({NM, ".rdy"}, longint'(IF.load_ready), 1); \
                if (IF.load_valid) begin \
                    if (nhs == 0) hsa = cyc; \
                    else if (nhs == 1) hsb = cyc; \
                    st = 1; rs = 0; rb = nhs; nhs++; \
                end \
            end \
            cyc++; \
        end \
        if (cyc >= 600) chk({NM, ".timeout"}, longint'(cyc), 0); \
        IF.load_valid = 0; \
        IF.enable = 0; \
    end

module tb_skewed_feeder;
    logic clk;
    logic reset;

    logic [15:0] elem [0:2][0:7][0:6];

    int nvec, nerr;
    int rs, rb, cyc, nhs, ndn, nvl, hsa, hsb;
    bit st;

    skewed_feeder_if #(.DATA_W(8),  .DEPTH(7), .LANES(4)) m0 ();
    skewed_feeder_if #(.DATA_W(16), .DEPTH(1), .LANES(1)) m1 ();
    skewed_feeder_if #(.DATA_W(8),  .DEPTH(3), .LANES(8)) m2 ();
    skewed_feeder_if #(.DATA_W(4),  .DEPTH(7), .LANES(2)) m3 ();

    skewed_feeder #(.DATA_W(8),  .DEPTH(7), .LANES(4)) u0 (.clk(clk), .reset(reset), .bus(m0.slave));
    skewed_feeder #(.DATA_W(16), .DEPTH(1), .LANES(1)) u1 (.clk(clk), .reset(reset), .bus(m1.slave));
    skewed_feeder #(.DATA_W(8),  .DEPTH(3), .LANES(8)) u2 (.clk(clk), .reset(reset), .bus(m2.slave));
    skewed_feeder #(.DATA_W(4),  .DEPTH(7), .LANES(2)) u3 (.clk(clk), .reset(reset), .bus(m3.slave));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic longint exp_word(int b, int s, int dw, int dp, int ln);
        longint w;
        longint m;
        w = 0;
        m = (longint'(1) << dw) - 1;
        for (int i = 0; i < ln; i++)
            if (s >= i && s - i < dp)
                w |= (longint'(elem[b][i][s-i]) & m) << (i * dw);
        return w;
    endfunction

    function automatic logic [223:0] pack0(int b);
        logic [223:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 7; k++)
                p[(i*7+6-k)*8 +: 8] = elem[b][i][k][7:0];
        return p;
    endfunction

    task automatic fill_rand();
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < 7; k++)
                    elem[b][i][k] = 16'($urandom);
    endtask

    int e_sgn [3];

    initial begin
        nvec = 0;
        nerr = 0;
        e_sgn = '{-128, 127, -1};
        reset = 1;
        m0.load_valid = 0; m0.load_data = '0; m0.enable = 0; m0.abort = 0;
        m1.load_valid = 0; m1.load_data = '0; m1.enable = 0; m1.abort = 0;
        m2.load_valid = 0; m2.load_data = '0; m2.enable = 0; m2.abort = 0;
        m3.load_valid = 0; m3.load_data = '0; m3.enable = 0; m3.abort = 0;

        @(negedge clk);
        chk("rst_rdy",  longint'(m0.load_ready), 1);
        chk("rst_ov",   longint'(m0.out_valid), 0);
        chk("rst_done", longint'(m0.done), 0);
        chk("rst_dat",  longint'(m0.data_out), 0);
        @(posedge clk); #1;
        reset = 0;

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 7; k++)
                elem[0][i][k] = 16'(16 * i + k);
        m0.load_data  = pack0(0);
        m0.load_valid = 1;
        @(negedge clk);
        chk("sk_rdy", longint'(m0.load_ready), 1);
        @(posedge clk); #1;
        m0.load_valid = 0;
        m0.enable     = 1;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            chk("sk_ov", longint'(m0.out_valid), 1);
            if (s == 0) chk("sk_step0", longint'(m0.data_out), 32'h0000_0000);
            if (s == 3) chk("sk_step3", longint'(m0.data_out), 32'h3021_1203);
            if (s == 9) chk("sk_step9", longint'(m0.data_out), 32'h3600_0000);
            chk("sk_done", longint'(m0.done), longint'(s == 9));
            @(posedge clk); #1;
        end
        m0.enable = 0;
        @(negedge clk);
        chk("sk_rdy_after", longint'(m0.load_ready), 1);
        chk("sk_ov_after",  longint'(m0.out_valid), 0);

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 7; k++)
                elem[1][i][k] = 16'(8'h11 * (i + 1) + k);
        elem[1][0][0] = 16'h0080;
        elem[1][0][1] = 16'h007F;
        elem[1][0][2] = 16'h00FF;
        @(posedge clk); #1;
        m0.load_data  = pack0(1);
        m0.load_valid = 1;
        @(posedge clk); #1;
        m0.load_valid = 0;
        for (int j = 0; j < 6; j++) begin
            m0.enable = (j % 2 == 1);
            @(negedge clk);
            chk("gap_l0", longint'($signed(m0.data_out[7:0])), longint'(e_sgn[j/2]));
            chk("gap_done", longint'(m0.done), 0);
            @(posedge clk); #1;
        end
        m0.enable = 1;
        for (int s = 3; s < 9; s++) begin
            @(negedge clk);
            chk("gap_run", longint'(m0.data_out), exp_word(1, s, 8, 7, 4));
            @(posedge clk); #1;
        end
        m0.abort = 1;
        @(negedge clk);
        chk("ab_last", longint'(m0.data_out), exp_word(1, 9, 8, 7, 4));
        chk("ab_done", longint'(m0.done), 0);
        chk("ab_rdy",  longint'(m0.load_ready), 0);
        @(posedge clk); #1;
        m0.abort  = 0;
        m0.enable = 0;
        @(negedge clk);
        chk("ab_ov",   longint'(m0.out_valid), 0);
        chk("ab_rdy2", longint'(m0.load_ready), 1);

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 7; k++)
                elem[2][i][k] = 16'(8'hA0 + 8 * i + k);
        @(posedge clk); #1;
        m0.load_data  = pack0(2);
        m0.load_valid = 1;
        @(posedge clk); #1;
        m0.load_valid = 0;
        m0.enable     = 1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("new_dat", longint'(m0.data_out), exp_word(2, s, 8, 7, 4));
            @(posedge clk); #1;
        end
        #1;
        reset = 1;
        #1;
        chk("rs_ov",  longint'(m0.out_valid), 0);
        chk("rs_dat", longint'(m0.data_out), 0);
        chk("rs_rdy", longint'(m0.load_ready), 1);
        @(posedge clk); #1;
        reset = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("rs_hold", longint'(m0.out_valid), 0);
            @(posedge clk); #1;
        end
        chk("rs_hold_dat", longint'(m0.data_out), 0);

        `RUN_BLOCKS(m0, 8, 7, 4, 2, 0, "b2b")
        chk("b2b_period", longint'(hsb - hsa), 11);
        chk("b2b_steps",  longint'(nvl), 20);
        chk("b2b_dones",  longint'(ndn), 2);

        fill_rand();
        `RUN_BLOCKS(m1, 16, 1, 1, 3, 1, "sw1")
        chk("sw1_dones", longint'(ndn), 3);
        chk("sw1_steps", longint'(nvl), 3);

        fill_rand();
        `RUN_BLOCKS(m2, 8, 3, 8, 3, 1, "sw2")
        chk("sw2_dones", longint'(ndn), 3);
        chk("sw2_steps", longint'(nvl), 30);

        fill_rand();
        `RUN_BLOCKS(m3, 4, 7, 2, 3, 1, "sw3")
        chk("sw3_dones", longint'(ndn), 3);
        chk("sw3_steps", longint'(nvl), 24);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/skewed_feeder.md
# skewed_feeder

Multi-lane, parametrised operand feeder for the systolic MAC array. It accepts a full operand block over a valid/ready load handshake, holding `DEPTH` elements per lane across `LANES` lanes. It then streams one element per lane per `enable` pulse, with lane *i* delayed by *i* steps. This produces the diagonal wavefront the array's row or column edge expects. Zeros pad the skew head and tail, and a `done` strobe marks the last step so the controller can issue the next block.

## Interface
- `DATA_W`, default 8: element width in bits; elements are signed two's complement.
- `DEPTH`, default 7: elements per lane per block; must be ≥ 1.
- `LANES`, default 4: number of parallel output lanes; must be ≥ 1.

- `clk`: input, 1 bit. Clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Reset, asynchronous, active-high.
- `load_valid`: input, 1 bit. A block is presented on `load_data`.
- `load_ready`: output, 1 bit. The feeder can accept a block.
- `load_data`: input, `LANES*DEPTH*DATA_W` bits. Lane *i* occupies bits `[(i+1)*DEPTH*DATA_W-1 : i*DEPTH*DATA_W]`. Within a lane, element 0 is the most significant `DATA_W` bits.
- `enable`: input, 1 bit. Advance one stream step.
- `abort`: input, 1 bit. Synchronous discard of the current block.
- `data_out`: output, `LANES*DATA_W` bits. Lane *i* is at `[(i+1)*DATA_W-1 : i*DATA_W]`; each lane is signed.
- `out_valid`: output, 1 bit. `data_out` is a stream step.
- `done`: output, 1 bit. The current step is the last step of the block.

## Operation
- **States:** IDLE and STREAM. Step counter `cnt` has width `$clog2(DEPTH+LANES)`. `LAST = DEPTH+LANES-2`.
- **Reset:** state is IDLE, `cnt` is 0, and all block storage is 0. Output reset values:
  - `load_ready` = 1
  - `out_valid` = 0
  - `done` = 0
  - `data_out` = 0
- **`load_ready`** = (state == IDLE) && !abort.
- **IDLE:**
  - When `load_valid && load_ready`, `load_data` is captured into block storage, `cnt` is set to 0, and the state moves to STREAM.
  - `enable` is ignored in IDLE.
- **STREAM:**
  - `out_valid` = 1.
  - Lane *i* drives element `cnt-i` when `i ≤ cnt ≤ i+DEPTH-1`, and 0 otherwise.
  - `data_out` is a combinational mux from storage and `cnt`. There is no arithmetic on data; elements pass bit-exact.
  - `enable` with `cnt < LAST`: `cnt` increments by 1.
  - `enable` with `cnt == LAST`: `done` = 1 in that same cycle, and the next state is IDLE with `cnt` = 0.
  - Without `enable`, `cnt` and `data_out` hold.
  - `load_valid` is ignored in STREAM, because `load_ready` = 0.
- **`abort`:**
  - Any state: next state is IDLE, `cnt` = 0, and storage is cleared to 0.
  - `done` is not asserted, even if `enable` is high with `cnt == LAST`.
  - Abort has priority over both load and enable.
- **Degenerate cases:**
  - `LANES=1`: no skew; `LAST = DEPTH-1`.
  - `DEPTH=1, LANES=1`: single-step block; `done` is asserted on the first enable.
- **Asynchronous reset mid-stream:** the block is discarded immediately and all outputs take their reset values.

## Timing
- **Load to stream latency:** 1 cycle. `out_valid` and `data_out` lane 0 = element 0 are visible in the cycle after the load handshake.
- **Stream length:** exactly `DEPTH+LANES-1` enable pulses per block.
- **Enabled stream step:** element `k` of lane *i* appears at stream step `k+i`, counting the first STREAM cycle as step 0.
- **Back-to-back throughput:**
  - `load_ready` rises in the cycle after the `done` cycle.
  - Minimum block period is `DEPTH+LANES` cycles with continuous `enable` and `load_valid`.
- **Signal timing:**
  - `done` is combinational, asserted only in the cycle it qualifies an enable.
  - `out_valid` is purely a function of state.

## Test plan
- **Reset value and storage:** reset asserted mid-STREAM with `LANES=4, DEPTH=7` → within the same cycle `out_valid` = 0, `data_out` = 0, and `load_ready` = 1. Releasing reset and then enabling 20 cycles → no output change.
- **Basic skew:** lane *i* element *k* loaded as `16*i+k`, then continuous `enable` → step 0 = {0,0,0,0x00}; step 3 = {0x30,0x21,0x12,0x03}; step 9 = {0x36,0,0,0}, with `done` = 1 at step 9 only. `load_ready` = 1 on the next cycle.
- **Gapped enable and signedness:** lane 0 = {0x80,0x7F,0xFF,…}, with `enable` toggling every other cycle → each value holds for 2 cycles; `data_out` lane 0 reads −128, 127, −1 in sequence; `cnt` advances only on enabled cycles.
- **Abort at `cnt == LAST` with `enable`:** → `done` stays 0, next cycle is IDLE, and storage is 0. A new load then streams the new data, not the old.
- **Back-to-back blocks:** `load_valid` held high with two distinct blocks and continuous `enable` → the second handshake occurs exactly `DEPTH+LANES` cycles after the first. No step is lost or duplicated; 20 valid steps in total for `LANES=4, DEPTH=7`.
- **Parameter sweep:** (`DATA_W`, `DEPTH`, `LANES`) = (16, 1, 1), (8, 3, 8), (4, 7, 2) with random data → a scoreboard model of the skew rule matches every cycle, and `done` count equals block count.
